// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator; VGA_TEST_PATTERN_EN enables colour-bar test pattern
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       pix_en,
  output logic [9:0] x_val,
  output logic [9:0] y_val,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic [2:0] test_rgb
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_end_q, line_end_d;
  logic       frame_start_q, frame_start_d;
  logic       line_wrap, frame_wrap;

  // Next position plus all decodes taken from that next position, so every
  // registered output lines up with x_val/y_val in the same cycle.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    line_wrap   = pix_en && (x_q == H_LAST);
    frame_wrap  = line_wrap && (y_q == V_LAST);
    if (pix_en) begin
      x_d = line_wrap ? 10'd0 : x_q + 10'd1;
    end
    if (line_wrap) begin
      y_d = frame_wrap ? 10'd0 : y_q + 10'd1;
    end
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
    hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (x_d < H_VIS_W) && (y_d < V_VIS_W);
    line_end_d    = pix_en && (x_d == H_LAST);
    frame_start_d = frame_wrap;
  end

  // Raster state and registered outputs; pulses drop on any non-advancing edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      frame_cnt_q   <= 8'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Eight equal-width vertical bars across the visible area.
  localparam int         BAR_W   = (H_VIS >= 8) ? (H_VIS / 8) : 1;
  localparam logic [9:0] BAR_W_V = 10'(BAR_W);

  logic [2:0] rgb_q, rgb_d;

  // Bar index from the next column, blanked outside the visible window.
  always_comb begin
    rgb_d = 3'b000;
    if (video_on_d) begin
      rgb_d = 3'(x_d / BAR_W_V);
    end
  end

  // Register the colour so it tracks x_val without skew.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign test_rgb = rgb_q;
`else
  assign test_rgb = 3'b000;
`endif

  assign x_val       = x_q;
  assign y_val       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen with a reduced raster geometry
module tb_vga_timing_gen;

  localparam int H_VIS = 16, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_VIS = 6,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam bit SP    = 1'b0;
  localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int TOT   = HT * VT;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] x_val, y_val;
  logic       hsync, vsync, video_on, line_end, frame_start;
  logic [7:0] frame_cnt;
  logic [2:0] test_rgb;

  int total = 0;
  int bad   = 0;

  logic [35:0] exp_q[$];

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SP)
  ) dut (
    .clk(clk), .nrst(nrst), .pix_en(pix_en),
    .x_val(x_val), .y_val(y_val), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .line_end(line_end), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .test_rgb(test_rgb)
  );

  always #5 clk = ~clk;

  // Expected outputs for raster index p, straight from the timing rules.
  function automatic logic [35:0] mk(int p, int f, bit le, bit fs);
    int x, y, rgb;
    bit hs, vs, von;
    x   = p % HT;
    y   = p / HT;
    hs  = (x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC) ? SP : ~SP;
    vs  = (y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC) ? SP : ~SP;
    von = (x < H_VIS) && (y < V_VIS);
    rgb = 0;
`ifdef VGA_TEST_PATTERN_EN
    if (von) rgb = x / (H_VIS / 8);
`endif
    return {10'(x), 10'(y), hs, vs, von, le, fs, 8'(f), 3'(rgb)};
  endfunction

  function automatic logic [35:0] actual();
    return {x_val, y_val, hsync, vsync, video_on, line_end, frame_start, frame_cnt, test_rgb};
  endfunction

  task automatic report(string name, logic [35:0] a, logic [35:0] e);
    $display("FAIL %s t=%0t got x=%0d y=%0d hs=%0b vs=%0b von=%0b le=%0b fs=%0b fc=%0d rgb=%0d expected x=%0d y=%0d hs=%0b vs=%0b von=%0b le=%0b fs=%0b fc=%0d rgb=%0d",
             name, $time, a[35:26], a[25:16], a[15], a[14], a[13], a[12], a[11], a[10:3], a[2:0],
             e[35:26], e[25:16], e[15], e[14], e[13], e[12], e[11], e[10:3], e[2:0]);
  endtask

  // Reference model: linear pixel index advanced on every enabled edge.
  initial begin
    int p, f;
    bit le, fs;
    p = 0;
    f = 0;
    forever begin
      @(posedge clk);
      le = 1'b0;
      fs = 1'b0;
      if (!nrst) begin
        p = 0;
        f = 0;
      end else if (pix_en) begin
        p = (p + 1) % TOT;
        if (p == 0) begin
          f  = (f + 1) % 256;
          fs = 1'b1;
        end
        le = (p % HT) == HT - 1;
      end
      exp_q.push_back(mk(p, f, le, fs));
    end
  end

  // Monitor: every falling edge compares the DUT against the oldest expectation.
  initial begin
    logic [35:0] e, a;
    forever begin
      @(negedge clk);
      a = actual();
      if (!nrst) begin
        e = mk(0, 0, 1'b0, 1'b0);
        exp_q.delete();
        total++;
        if (a !== e) begin bad++; report("reset_state", a, e); end
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL no_expectation t=%0t got x=%0d y=%0d required queued entry", $time, x_val, y_val);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin bad++; report("outputs", a, e); end
      end
    end
  end

  // mode 0: always enabled, 1: alternating, 2: random
  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0:       pix_en = 1'b1;
        1:       pix_en = ~pix_en;
        default: pix_en = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    logic [35:0] e, a;
    bit found;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;

    run(257 * TOT + 37, 0);
    run(4 * TOT, 1);
    run(6 * TOT, 2);

    // Reach a mid-frame position, then hit async reset between edges.
    found = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 2 * TOT; i++) begin
      @(negedge clk);
      if (x_val == 10'(HT - 4) && y_val == 10'(V_VIS / 2)) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_midframe got x=%0d y=%0d required x=%0d y=%0d", x_val, y_val, HT - 4, V_VIS / 2);
    end
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    a = actual();
    e = mk(0, 0, 1'b0, 1'b0);
    total++;
    if (a !== e) begin bad++; report("async_reset", a, e); end
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;

    run(3 * TOT, 2);
    run(2 * TOT, 1);
    run(TOT + 11, 0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
